// File: rtl/matrix_scan_driver_pkg.sv
// Shared constants and types for the 7x5 LED matrix column scanner.
package matrix_pkg;
  localparam int MTX_ROWS = 7;
  localparam int MTX_COLS = 5;
  localparam int IDX_W    = 3;
  localparam logic [MTX_ROWS-1:0] PIX_OFF = 7'b1111111;

  // Width for the nominal 10000-tick slot; modules recompute it from their own parameter.
  localparam int TICKS_PER_COL_DEFAULT = 10000;
  localparam int CNT_W = $clog2(TICKS_PER_COL_DEFAULT);

  typedef logic [MTX_ROWS-1:0] col_pat_t;

  // Counter width able to hold 0..ticks-1 (never narrower than one bit).
  function automatic int cnt_width(input int ticks);
    return (ticks > 2) ? $clog2(ticks) : 1;
  endfunction
endpackage

// File: rtl/matrix_scan_driver_if.sv
// Pattern inputs and matrix drive outputs of the column scanner.
interface matrix_scan_if;
  import matrix_pkg::*;

  logic                  enable;
  col_pat_t              col1_in;
  col_pat_t              col2_in;
  col_pat_t              col3_in;
  col_pat_t              col4_in;
  col_pat_t              col5_in;
  logic [MTX_COLS-1:0]   col_en;
  col_pat_t              row_n;
  logic                  frame_start;

  // Upstream side: supplies patterns and enable, observes the drive.
  modport master (
    output enable, col1_in, col2_in, col3_in, col4_in, col5_in,
    input  col_en, row_n, frame_start
  );

  // Scanner side.
  modport slave (
    input  enable, col1_in, col2_in, col3_in, col4_in, col5_in,
    output col_en, row_n, frame_start
  );
endinterface

// File: rtl/matrix_scan_driver_scan_tick_gen.sv
// Slot tick counter and column index; both held at zero while disabled.
module scan_tick_gen
  import matrix_pkg::*;
#(
  parameter int TICKS_PER_COL = 10000,
  parameter int CW            = cnt_width(TICKS_PER_COL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic [CW-1:0]    cnt,
  output logic [IDX_W-1:0] idx,
  output logic             slot_first
);
  localparam logic [CW-1:0]    CNT_LAST = CW'(TICKS_PER_COL - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MTX_COLS - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Next count: advance within the slot, step column at slot end, wrap after the last column.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!enable) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign cnt        = cnt_q;
  assign idx        = idx_q;
  assign slot_first = (cnt_q == '0);
endmodule

// File: rtl/matrix_scan_driver.sv
// Column-multiplexed driver for a 7x5 LED matrix with frame-latched patterns
// and a blanking gap at the start of every column slot.
module matrix_scan_driver
  import matrix_pkg::*;
#(
  parameter int TICKS_PER_COL = 10000,
  parameter int BLANK_TICKS   = 500
) (
  input  logic          clk,
  input  logic          rst,
  matrix_scan_if.slave  bus
);
  localparam int CW = cnt_width(TICKS_PER_COL);

  logic [CW-1:0]    cnt;
  logic [IDX_W-1:0] idx;
  logic             slot_first;
  logic             shadow_load;

  col_pat_t col_in   [MTX_COLS];
  col_pat_t shadow_q [MTX_COLS];
  col_pat_t shadow_d [MTX_COLS];

  logic [MTX_COLS-1:0] col_en_q, col_en_d;
  col_pat_t            row_n_q, row_n_d;
  logic                frame_start_q, frame_start_d;

  scan_tick_gen #(
    .TICKS_PER_COL (TICKS_PER_COL),
    .CW            (CW)
  ) u_tick (
    .clk        (clk),
    .rst        (rst),
    .enable     (bus.enable),
    .cnt        (cnt),
    .idx        (idx),
    .slot_first (slot_first)
  );

  assign col_in[0] = bus.col1_in;
  assign col_in[1] = bus.col2_in;
  assign col_in[2] = bus.col3_in;
  assign col_in[3] = bus.col4_in;
  assign col_in[4] = bus.col5_in;

  // Patterns are latched only while idle or on the first tick of a frame, so a frame never tears.
  assign shadow_load = !bus.enable || (slot_first && (idx == '0));

  // Shadow bank next value: all columns captured together.
  always_comb begin
    for (int i = 0; i < MTX_COLS; i++) begin
      shadow_d[i] = shadow_load ? col_in[i] : shadow_q[i];
    end
  end

  for (genvar gi = 0; gi < MTX_COLS; gi++) begin : g_shadow
    // One shadow register per column, blank after reset.
    always_ff @(posedge clk) begin
      if (rst) shadow_q[gi] <= PIX_OFF;
      else     shadow_q[gi] <= shadow_d[gi];
    end
  end

  // Decode column drive from registered state; blank gap keeps old rows off the new column.
  always_comb begin
    col_en_d      = '0;
    row_n_d       = PIX_OFF;
    frame_start_d = 1'b0;
    if (bus.enable) begin
      frame_start_d = slot_first && (idx == '0);
      if (cnt >= CW'(BLANK_TICKS)) begin
        for (int i = 0; i < MTX_COLS; i++) begin
          if (idx == IDX_W'(i)) begin
            col_en_d[i] = 1'b1;
            row_n_d     = shadow_q[i];
          end
        end
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_en_q      <= '0;
      row_n_q       <= PIX_OFF;
      frame_start_q <= 1'b0;
    end else begin
      col_en_q      <= col_en_d;
      row_n_q       <= row_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.col_en      = col_en_q;
  assign bus.row_n       = row_n_q;
  assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_matrix_scan_driver.sv
// Directed bench for matrix_scan_driver with 8-tick slots and 2-tick blanking.
module tb_matrix_scan_driver;
  import matrix_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_scan_if bus();

  matrix_scan_driver #(
    .TICKS_PER_COL (8),
    .BLANK_TICKS   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         lo;
    int         hi;
    logic [4:0] ce;
    logic [6:0] rn;
    logic       fs;
  } exp_t;

  exp_t       exp_q[$];
  logic [6:0] fp[5];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, c, act, req);
    end
  endtask

  task automatic add(input int lo, input int hi, input logic [4:0] ce, input logic [6:0] rn, input logic fs);
    exp_t e;
    e.lo = lo; e.hi = hi; e.ce = ce; e.rn = rn; e.fs = fs;
    exp_q.push_back(e);
  endtask

  // Expected outputs for cycles b+1..b+40 when a frame starts its state at cycle b.
  task automatic add_frame(input int b);
    add(b + 1, b + 1, 5'b00000, 7'h7F, 1'b1);
    add(b + 2, b + 2, 5'b00000, 7'h7F, 1'b0);
    for (int k = 0; k < 5; k++) begin
      add(b + 3 + 8 * k, b + 8 + 8 * k, 5'(1 << k), fp[k], 1'b0);
      if (k > 0) add(b + 1 + 8 * k, b + 2 + 8 * k, 5'b00000, 7'h7F, 1'b0);
    end
  endtask

  task automatic set_col(input int k, input logic [6:0] v);
    case (k)
      0: bus.col1_in = v;
      1: bus.col2_in = v;
      2: bus.col3_in = v;
      3: bus.col4_in = v;
      default: bus.col5_in = v;
    endcase
  endtask

  task automatic load_defaults();
    fp[0] = 7'b0111100; fp[1] = 7'b0011101; fp[2] = 7'b0110101;
    fp[3] = 7'b1000111; fp[4] = 7'b1110111;
    for (int k = 0; k < 5; k++) set_col(k, fp[k]);
  endtask

  // Three reset cycles with enable high; outputs must sit at reset values. Leaves us at cycle 0 start.
  task automatic do_reset();
    rst        = 1'b1;
    bus.enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_col_en", -3 + i, 32'(bus.col_en), 32'h00);
      chk("rst_row_n", -3 + i, 32'(bus.row_n), 32'h7F);
      chk("rst_frame_start", -3 + i, 32'(bus.frame_start), 32'h0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input int en_lo, input int en_hi, input int rst_c,
                     input int chg_c, input int chg_k, input logic [6:0] chg_v);
    for (int c = 0; c < n; c++) begin
      rst        = (c == rst_c);
      bus.enable = !(c >= en_lo && c <= en_hi);
      if (c == chg_c) set_col(chg_k, chg_v);
      @(negedge clk);
      foreach (exp_q[i]) begin
        if (c >= exp_q[i].lo && c <= exp_q[i].hi) begin
          chk("col_en", c, 32'(bus.col_en), 32'(exp_q[i].ce));
          chk("row_n", c, 32'(bus.row_n), 32'(exp_q[i].rn));
          chk("frame_start", c, 32'(bus.frame_start), 32'(exp_q[i].fs));
        end
      end
      $display("cycle %0d: en=%0b col_en=%b row_n=%b fs=%0b", c, bus.enable, bus.col_en, bus.row_n, bus.frame_start);
      @(posedge clk);
      #1;
    end
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    bus.enable = 1'b1;
    load_defaults();

    // Reset, pattern mapping, tear-free update of column 3 at cycle 12.
    do_reset();
    add(0, 0, 5'b00000, 7'h7F, 1'b0);
    add_frame(0);
    fp[2] = 7'b0000000;
    add_frame(40);
    run(81, -1, -1, -1, 12, 2, 7'b0000000);

    // Enable low for cycles 20..24; column 2 changes while idle and shows after restart.
    load_defaults();
    do_reset();
    add(0, 0, 5'b00000, 7'h7F, 1'b0);
    add(1, 1, 5'b00000, 7'h7F, 1'b1);
    add(2, 2, 5'b00000, 7'h7F, 1'b0);
    add(3, 8, 5'b00001, fp[0], 1'b0);
    add(9, 10, 5'b00000, 7'h7F, 1'b0);
    add(11, 16, 5'b00010, fp[1], 1'b0);
    add(17, 18, 5'b00000, 7'h7F, 1'b0);
    add(19, 20, 5'b00100, fp[2], 1'b0);
    add(21, 25, 5'b00000, 7'h7F, 1'b0);
    fp[1] = 7'b1100110;
    add_frame(25);
    run(66, 20, 24, -1, 22, 1, 7'b1100110);

    // Reset pulse at cycle 30 during column 4; first frame after it shows the live column 1.
    load_defaults();
    do_reset();
    add(0, 0, 5'b00000, 7'h7F, 1'b0);
    add(1, 1, 5'b00000, 7'h7F, 1'b1);
    add(2, 2, 5'b00000, 7'h7F, 1'b0);
    add(3, 8, 5'b00001, fp[0], 1'b0);
    add(11, 16, 5'b00010, fp[1], 1'b0);
    add(19, 24, 5'b00100, fp[2], 1'b0);
    add(27, 30, 5'b01000, fp[3], 1'b0);
    add(31, 31, 5'b00000, 7'h7F, 1'b0);
    fp[0] = 7'b1010101;
    add_frame(31);
    run(72, -1, -1, 30, 10, 0, 7'b1010101);

    // Long run: frame period, one-hot drive, blank at frame start.
    load_defaults();
    do_reset();
    rst = 1'b0;
    bus.enable = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      chk("period_frame_start", c, 32'(bus.frame_start), 32'((c % 40) == 1));
      chk("onehot0_col_en", c, 32'($onehot0(bus.col_en)), 32'h1);
      if (bus.frame_start) chk("blank_at_frame_start", c, 32'(bus.col_en), 32'h0);
      @(posedge clk);
      #1;
    end
    $display("long run: 1000 cycles checked");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Backstop so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: bench still running at %0t, expected completion earlier", $time);
    $fatal(1, "timeout");
  end
endmodule
